scan_test_ctrl: RTL and testbench

Sequencer for full-scan testing of the CPU netlist. Pulls stimulus and expected-response bits from a pattern source over a valid/ready stream, drives the scan-enable, capture and scan-in pins of the scanned CPU, and compares the unloaded response against expectation. Loading of pattern k+1 overlaps unloading of response k. Reports a sticky fail flag, a saturating mismatch count and, optionally, a response signature.

---
 rtl/scan_test_ctrl_pkg.sv | 26 ++
 rtl/scan_misr.sv | 35 +++
 rtl/scan_test_ctrl.sv | 171 +++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_test_ctrl_pkg.sv
// scan_test_ctrl_pkg
// Shared types and constants for the full-scan test sequencer:
//   state_t    - sequencer FSM states
//   SIG_W      - response signature width
//   MISR_POLY  - feedback taps for x^16+x^12+x^5+1 (x^16 term implicit)
//   misr_step  - one MISR update absorbing a single serial bit
package scan_test_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int SIG_W = 16;
   localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

   // Shift left, bring the new bit in at the LSB, and fold the bit that
   // falls off the top back in through the polynomial taps.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                  input logic din);
      return {s[SIG_W-2:0], din} ^ (s[SIG_W-1] ? MISR_POLY : '0);
   endfunction

endpackage

// File: rtl/scan_misr.sv
// scan_misr
// Single-input 16-bit MISR compacting the unloaded scan response.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr         - reseed to 0 (session start)
//   en          - absorb din this cycle
//   din         - serial response bit
//   sig         - current MISR value
module scan_misr
   import scan_test_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr)     sig_d = '0;
      else if (en) sig_d = misr_step(sig_q, din);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) sig_q <= '0;
      else        sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl
// Full-scan sequencer. Streams stimulus/expected bit pairs from a
// valid/ready source into a single scan chain, pulses capture between
// patterns and compares the unloaded response while the next pattern
// loads. A final unload-only pass empties the last response.
// Optional response MISR: define SCAN_TEST_CTRL_MISR_EN.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   start, num_pat       - begin session (IDLE only), pattern count
//   pat_valid/pat_ready  - source handshake; pat_bit stimulus, exp_bit
//                          expected response of the previous pattern
//   scan_en, capture     - chain shift / functional capture strobes
//   scan_in, scan_out    - chain serial in / chain tail
//   busy, done           - session active / one-cycle completion pulse
//   fail, err_cnt        - sticky mismatch flag, saturating mismatch count
//   signature            - MISR value (0 when the MISR is not built)
module scan_test_ctrl
   import scan_test_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN = 56,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_pat,
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic             pat_bit,
   input  logic             exp_bit,
   output logic             scan_en,
   output logic             capture,
   output logic             scan_in,
   input  logic             scan_out,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] err_cnt,
   output logic [SIG_W-1:0] signature
);

   localparam int              BIT_W    = $clog2(CHAIN_LEN);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] num_pat_q, num_pat_d;
   logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             first_q,   first_d;
   logic             fail_q,    fail_d;

   logic xfer;      // handshake completes this cycle
   logic loading;   // this pass still carries stimulus
   logic cmp_en;    // transfer that also unloads a real response
   logic mismatch;

   always_comb begin
      state_d   = state_q;
      num_pat_d = num_pat_q;
      pat_cnt_d = pat_cnt_q;
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      first_d   = first_q;
      fail_d    = fail_q;
      pat_ready = 1'b0;
      scan_en   = 1'b0;
      capture   = 1'b0;
      scan_in   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      xfer      = 1'b0;
      cmp_en    = 1'b0;
      mismatch  = 1'b0;
      // Once every pattern has been captured the pass only unloads.
      loading   = (pat_cnt_q < num_pat_q);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_pat_d = num_pat;
               pat_cnt_d = '0;
               bit_cnt_d = '0;
               err_cnt_d = '0;
               fail_d    = 1'b0;
               first_d   = 1'b1;
               state_d   = (num_pat == '0) ? ST_DONE : ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            busy      = 1'b1;
            pat_ready = 1'b1;
            xfer      = pat_valid;
            // Chain only moves on a real transfer so stalls hold it.
            scan_en   = xfer;
            scan_in   = loading & pat_bit;
            if (xfer) begin
               // The first pass unloads power-up garbage: no compare.
               cmp_en   = ~first_q;
               mismatch = cmp_en & (scan_out ^ exp_bit);
               if (mismatch) begin
                  fail_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
               end
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = loading ? ST_CAPTURE : ST_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         ST_CAPTURE: begin
            busy      = 1'b1;
            capture   = 1'b1;
            pat_cnt_d = pat_cnt_q + 1'b1;
            first_d   = 1'b0;
            state_d   = ST_SHIFT;
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         num_pat_q <= '0;
         pat_cnt_q <= '0;
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
         first_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_pat_q <= num_pat_d;
         pat_cnt_q <= pat_cnt_d;
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         first_q   <= first_d;
         fail_q    <= fail_d;
      end
   end

   assign fail    = fail_q;
   assign err_cnt = err_cnt_q;

`ifdef SCAN_TEST_CTRL_MISR_EN
   logic misr_clr;
   assign misr_clr = (state_q == ST_IDLE) && start;

   scan_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (misr_clr),
      .en    (cmp_en),
      .din   (scan_out),
      .sig   (signature)
   );
`else
   assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl
// Drives scan_test_ctrl (CHAIN_LEN=8, CNT_W=8) against a behavioural
// 8-bit scan chain whose capture inverts its contents. The pattern
// source derives expected responses from the stimulus, optionally with
// injected flips, so the expected error count is simply the number of
// flipped expected bits.
module tb_scan_test_ctrl;

   localparam int L  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, pat_valid, pat_bit, exp_bit, scan_out;
   logic [CW-1:0] num_pat;
   logic          pat_ready, scan_en, capture, scan_in, busy, done, fail;
   logic [CW-1:0] err_cnt;
   logic [15:0]   signature;

   int n_vec = 0;
   int n_err = 0;

   logic [L-1:0] cut = '0;
   logic [L-1:0] stim  [64];
   logic [L-1:0] eflip [64];

   always #5 clk = ~clk;

   scan_test_ctrl #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_pat   (num_pat),
      .pat_valid (pat_valid),
      .pat_ready (pat_ready),
      .pat_bit   (pat_bit),
      .exp_bit   (exp_bit),
      .scan_en   (scan_en),
      .capture   (capture),
      .scan_in   (scan_in),
      .scan_out  (scan_out),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .err_cnt   (err_cnt),
      .signature (signature)
   );

   // Circuit under test: plain shift register, capture inverts it.
   assign scan_out = cut[L-1];
   always @(posedge clk) begin
      if (capture)      cut <= ~cut;
      else if (scan_en) cut <= {cut[L-2:0], scan_in};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Random stimulus for all patterns; nflips random expected-bit flips.
   task automatic fill(input int n, input int nflips);
      for (int p = 0; p < 64; p++) begin
         stim[p]  = L'($urandom);
         eflip[p] = '0;
      end
      if (n > 0)
         for (int f = 0; f < nflips; f++)
            eflip[$urandom_range(0, n-1)][$urandom_range(0, L-1)] = 1'b1;
   endtask

   // stall: 0 = valid always, 1 = valid every other cycle, 2 = random.
   // mid_start: pulse start (num_pat=0) while busy; must be ignored.
   task automatic run(input string nm, input int n, input int stall, input bit mid_start);
      int flips, idx, pass, b, c;
      int n_busy, n_caps, cap_first, n_xfer, n_en, bad_en, bad_rdy, bad_si, n_done, done_cyc;
      bit seen_done, xfer;
      logic [15:0] sig_m;
      flips = 0;
      for (int p = 0; p < n; p++)
         for (int k = 0; k < L; k++) flips += int'(eflip[p][k]);
      idx = 0; n_busy = 0; n_caps = 0; cap_first = 0; n_xfer = 0; n_en = 0;
      bad_en = 0; bad_rdy = 0; bad_si = 0; n_done = 0; done_cyc = 0;
      seen_done = 1'b0; sig_m = '0;

      @(negedge clk);
      start = 1'b1; num_pat = CW'(n); pat_valid = 1'b0;
      c = 0;
      while (!seen_done && c < 3000) begin
         @(negedge clk);
         c++;
         start = mid_start && (c == 5);
         if (c == 5) num_pat = '0;
         case (stall)
            0:       pat_valid = 1'b1;
            1:       pat_valid = c[0];
            default: pat_valid = 1'($urandom_range(0, 1));
         endcase
         pass = idx / L;
         b    = L - 1 - (idx % L);
         if (pass < n) pat_bit = stim[pass][b];
         else          pat_bit = 1'($urandom_range(0, 1));
         if (pass >= 1 && pass <= n) exp_bit = ~stim[pass-1][b] ^ eflip[pass-1][b];
         else                        exp_bit = 1'($urandom_range(0, 1));
         #1;
         xfer = pat_valid && pat_ready;
         if (busy) n_busy++;
         if (capture) begin
            n_caps++;
            if (cap_first == 0) cap_first = c;
         end
         if (pat_ready && (capture || !busy)) bad_rdy++;
         if (scan_en !== xfer) bad_en++;
         if (scan_en) n_en++;
         if (xfer) begin
            if (scan_in !== ((pass < n) ? pat_bit : 1'b0)) bad_si++;
            if (pass >= 1) sig_m = {sig_m[14:0], scan_out} ^ (sig_m[15] ? 16'h1021 : 16'h0);
            n_xfer++;
            idx++;
         end
         if (done) begin
            n_done++;
            done_cyc  = c;
            seen_done = 1'b1;
         end
      end
      if (!seen_done) chk({nm, "_timeout"}, 0, 1);
      @(negedge clk);
      start = 1'b0; pat_valid = 1'b0;
      #1;
      if (done) n_done++;
      chk({nm, "_done_once"}, n_done, 1);
      chk({nm, "_idle_busy"}, busy, 0);
      chk({nm, "_err_cnt"}, err_cnt, (flips > 255) ? 255 : flips);
      chk({nm, "_fail"}, fail, flips > 0);
      chk({nm, "_xfers"}, n_xfer, (n == 0) ? 0 : (n + 1) * L);
      chk({nm, "_scan_en_cnt"}, n_en, (n == 0) ? 0 : (n + 1) * L);
      chk({nm, "_captures"}, n_caps, n);
      chk({nm, "_scan_en_gate"}, bad_en, 0);
      chk({nm, "_ready_gate"}, bad_rdy, 0);
      chk({nm, "_scan_in"}, bad_si, 0);
      if (n > 0) chk({nm, "_chain_flushed"}, cut, 0);
      if (stall == 0) begin
         chk({nm, "_done_cycle"}, done_cyc, (n == 0) ? 1 : (n + 1) * L + n + 1);
         chk({nm, "_busy_cycles"}, n_busy, (n == 0) ? 0 : (n + 1) * L + n);
      end
`ifdef SCAN_TEST_CTRL_MISR_EN
      chk({nm, "_signature"}, signature, sig_m);
`else
      chk({nm, "_signature"}, signature, 0);
`endif
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; num_pat = '0;
      pat_valid = 1'b0; pat_bit = 1'b0; exp_bit = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_outs", {pat_ready, scan_en, capture, scan_in}, 0);
      chk("rst_sig", signature, 0);
      rst_n = 1'b1;

      fill(0, 0);
      run("zero", 0, 0, 1'b0);

      fill(1, 0);
      stim[0] = 8'hA5;
      run("a5", 1, 0, 1'b1);

      fill(3, 0);
      eflip[1][$urandom_range(0, L-1)] = 1'b1;
      run("flip_r2", 3, 0, 1'b1);

      fill(3, 1);
      run("nostall", 3, 0, 1'b0);
      run("toggle", 3, 1, 1'b0);

      // Reset in mid-session, then a fresh session.
      fill(3, 0);
      @(negedge clk);
      start = 1'b1; num_pat = 8'd3; pat_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) begin
         pat_bit = 1'($urandom_range(0, 1));
         exp_bit = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_fail_err", {fail, err_cnt}, 0);
      chk("mrst_outs", {pat_ready, scan_en, capture, scan_in, done}, 0);
      chk("mrst_sig", signature, 0);
      rst_n = 1'b1; pat_valid = 1'b0;
      fill(2, 2);
      run("post_rst", 2, 2, 1'b0);

      for (int s = 0; s < 6; s++) begin
         n = $urandom_range(0, 5);
         fill(n, $urandom_range(0, 3));
         run("rand", n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      // Every expected bit flipped: 320 mismatches saturate at 255.
      fill(40, 0);
      for (int p = 0; p < 40; p++) eflip[p] = '1;
      run("saturate", 40, 0, 1'b0);

`ifdef SCAN_TEST_CTRL_MISR_EN
      begin
         logic [15:0] s1;
         fill(2, 0);
         run("sig_a", 2, 0, 1'b0);
         s1 = signature;
         chk("sig_nonzero", s1 != 16'h0, 1);
         run("sig_b", 2, 2, 1'b0);
         chk("sig_repeat", signature, s1);
         stim[1][3] = ~stim[1][3];
         run("sig_c", 2, 0, 1'b0);
         chk("sig_differs", signature != s1, 1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
